// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, parity-type encodings and the
// default frame data width.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DATA_WIDTH_DEF = 8;

endpackage

// File: rtl/uart_tx_serializer.sv
// Data shift-out helper for uart_tx: holds the frame's data word and the bit
// counter, and reports the line level that the next edge must present.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_en,
  output logic                  o_next_bit,
  output logic                  o_ser_done
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] r_data;
  logic [CW-1:0]         r_bit_cnt;
  logic                  w_last;
  logic [CW-1:0]         w_next_cnt;

  assign w_last     = (r_bit_cnt == CW'(DATA_WIDTH - 1));
  assign w_next_cnt = w_last ? '0 : r_bit_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data    <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (i_load) r_data <= i_data;
      if (i_en)   r_bit_cnt <= w_next_cnt;
    end
  end

  // Outside DATA the next data bit can only be bit 0 (entry from START).
  assign o_next_bit = i_en ? r_data[w_next_cnt] : r_data[0];
  assign o_ser_done = i_en && w_last;

endmodule

// File: rtl/uart_tx.sv
// UART frame transmitter clocked at the bit rate: start, LSB-first data,
// optional parity, stop. Outputs are registered from the next-state value.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  Par_En,
  input  logic                  Par_Typ,
  output logic                  TX_OUT,
  output logic                  Busy
);

  uart_tx_state_t r_state, w_next_state;
  logic           r_par_en;
  logic           r_par_bit;
  logic           w_accept;
  logic           w_ser_en;
  logic           w_ser_done;
  logic           w_next_bit;
  logic           w_next_line;

  assign w_accept = Data_Valid && (r_state == IDLE);
  assign w_ser_en = (r_state == DATA);

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_data     (P_DATA),
    .i_en       (w_ser_en),
    .o_next_bit (w_next_bit),
    .o_ser_done (w_ser_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      TX_OUT    <= 1'b1;
      Busy      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      TX_OUT  <= w_next_line;
      Busy    <= (w_next_state != IDLE);
      if (w_accept) begin
        r_par_en  <= Par_En;
        r_par_bit <= (^P_DATA) ^ (Par_Typ == PAR_ODD);
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_line  = 1'b1;
    case (r_state)
      IDLE:    if (Data_Valid) w_next_state = START;
      START:   w_next_state = DATA;
      DATA:    if (w_ser_done) w_next_state = r_par_en ? PARITY : STOP;
      PARITY:  w_next_state = STOP;
      STOP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    case (w_next_state)
      START:   w_next_line = 1'b0;
      DATA:    w_next_line = w_next_bit;
      PARITY:  w_next_line = r_par_bit;
      default: w_next_line = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level reference model compared every
// cycle, plus literal expectations for the directed frames.
module tb_uart_tx;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          Data_Valid = 1'b0;
  logic          Par_En = 1'b0;
  logic          Par_Typ = 1'b0;
  logic          TX_OUT;
  logic          Busy;

  uart_tx #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .Par_En     (Par_En),
    .Par_Typ    (Par_Typ),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of line levels; rem counts the frame
  // cycles still to be shown after the current edge.
  int rem = 0;
  int flen = 0;
  bit fr[16];

  always @(posedge clk or posedge rst) begin
    if (rst) rem = 0;
    else if (rem > 0) rem--;
    else if (Data_Valid) begin
      flen = DW + 2 + (Par_En ? 1 : 0);
      fr[0] = 1'b0;
      for (int i = 0; i < DW; i++) fr[1+i] = P_DATA[i];
      if (Par_En) fr[DW+1] = ^{P_DATA, Par_Typ};
      fr[flen-1] = 1'b1;
      rem = flen;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_tx", {31'b0, TX_OUT}, {31'b0, (rem > 0) ? fr[flen-rem] : 1'b1});
      check("model_busy", {31'b0, Busy}, {31'b0, rem > 0});
    end
  end

  task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt);
    @(posedge clk); #1;
    P_DATA = d; Par_En = pe; Par_Typ = pt; Data_Valid = 1'b1;
    @(posedge clk); #1;
    Data_Valid = 1'b0;
  endtask

  task automatic capture(input int n, output logic [31:0] tx, output logic [31:0] bs);
    tx = '0; bs = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx[i] = TX_OUT;
      bs[i] = Busy;
    end
  endtask

  logic [31:0] tx, bs, txo, txe;

  initial begin
    #1 rst = 1'b1;
    #2;
    check("reset_tx", {31'b0, TX_OUT}, 32'h1);
    check("reset_busy", {31'b0, Busy}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    chk_on = 1'b1;

    // Even parity, 0xA5
    start_frame(8'hA5, 1'b1, 1'b0);
    capture(12, tx, bs);
    check("even_a5_seq", tx, 32'hD4A);
    check("even_a5_busy", bs, 32'h7FF);

    // Odd vs even on 0x01
    start_frame(8'h01, 1'b1, 1'b1);
    capture(12, txo, bs);
    start_frame(8'h01, 1'b1, 1'b0);
    capture(12, txe, bs);
    check("odd_par_bit", {31'b0, txo[9]}, 32'h0);
    check("even_par_bit", {31'b0, txe[9]}, 32'h1);
    check("odd_even_diff", txo ^ txe, 32'h200);

    // No parity, 0xFF, with inputs toggled mid-frame
    start_frame(8'hFF, 1'b0, 1'b0);
    fork
      capture(11, tx, bs);
      begin
        repeat (3) @(posedge clk);
        #1 Par_En = 1'b1; Par_Typ = 1'b1; P_DATA = 8'h00;
        repeat (3) @(posedge clk);
        #1 Par_En = 1'b0;
      end
    join
    check("nopar_ff_seq", tx, 32'h7FE);
    check("nopar_ff_busy", bs, 32'h3FF);

    // Back-to-back with Data_Valid held
    @(posedge clk); #1;
    P_DATA = 8'h3C; Par_En = 1'b1; Par_Typ = 1'b0; Data_Valid = 1'b1;
    @(posedge clk);
    fork
      capture(24, tx, bs);
      begin
        repeat (3) @(posedge clk);
        #1 P_DATA = 8'hC3;
        repeat (9) @(posedge clk);
        #1 Data_Valid = 1'b0;
      end
    join
    check("b2b_seq", tx, 32'hD86C78);
    check("b2b_busy", bs, 32'h7FF7FF);
    check("b2b_idle_gap", {30'b0, tx[12], tx[11]}, 32'h1);

    // Reset during data bit 3
    start_frame(8'hA5, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    check("pre_rst_tx", {31'b0, TX_OUT}, 32'h0);
    check("pre_rst_busy", {31'b0, Busy}, 32'h1);
    rst = 1'b1;
    #1;
    check("rst_async_tx", {31'b0, TX_OUT}, 32'h1);
    check("rst_async_busy", {31'b0, Busy}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    capture(5, tx, bs);
    check("post_rst_idle_tx", tx, 32'h1F);
    check("post_rst_idle_busy", bs, 32'h0);

    @(posedge clk); #1;
    rst = 1'b1; P_DATA = 8'h96; Par_En = 1'b0; Par_Typ = 1'b0; Data_Valid = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 Data_Valid = 1'b0;
    capture(11, tx, bs);
    check("post_rst_frame_seq", tx, 32'h72C);
    check("post_rst_frame_busy", bs, 32'h3FF);

    // Randomized traffic, checked by the model every cycle
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk); #1;
      P_DATA = 8'($urandom); Par_En = 1'($urandom); Par_Typ = 1'($urandom);
      Data_Valid = 1'b1;
      for (int k = 0; k < int'($urandom_range(1, 15)); k++) begin
        @(posedge clk); #1;
        P_DATA = 8'($urandom); Par_En = 1'($urandom); Par_Typ = 1'($urandom);
      end
      Data_Valid = 1'b0;
    end
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk_on = 1'b0;
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
